// File: rtl/mem_port_arbiter_if.sv
// Level-held read/write + resp bundle joining the I/D requesters, the arbiter and physical memory.
// Latency: none (wires only); backpressure: requesters hold strobes until their resp pulse.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int MASK_W = 2
);
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [DATA_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [MASK_W-1:0] d_byte_enable;
    logic [ADDR_W-1:0] d_address;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [MASK_W-1:0] pmem_byte_enable;
    logic [ADDR_W-1:0] pmem_address;
    logic [DATA_W-1:0] pmem_wdata;
    logic [DATA_W-1:0] pmem_rdata;
    logic              pmem_resp;

    // The arbiter itself: consumes requests and memory responses.
    modport slave (
        input  i_read, i_address,
        output i_rdata, i_resp,
        input  d_read, d_write, d_byte_enable, d_address, d_wdata,
        output d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_byte_enable, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    // The environment: requesters plus physical memory.
    modport master (
        output i_read, i_address,
        input  i_rdata, i_resp,
        output d_read, d_write, d_byte_enable, d_address, d_wdata,
        input  d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_byte_enable, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one physical memory port between instruction and data requesters.
// Latency: grant one cycle after request, resp forwarded same cycle; backpressure: loser's request stays pending.
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int MASK_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    state_t state_q;
    logic   last_grant_q;   // 0 = I, 1 = D

    logic i_req;
    logic d_req;
    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req && (!d_req || last_grant_q)) begin
                        state_q      <= SERVE_I;
                        last_grant_q <= 1'b0;
                    end else if (d_req) begin
                        state_q      <= SERVE_D;
                        last_grant_q <= 1'b1;
                    end
                end
                // Falling back to IDLE on resp or abort forces one idle cycle, so a
                // strobe dropped at the resp edge is never seen as a fresh request.
                SERVE_I: if (bus.pmem_resp || !i_req) state_q <= IDLE;
                SERVE_D: if (bus.pmem_resp || !d_req) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    logic              pmem_read_c;
    logic              pmem_write_c;
    logic [MASK_W-1:0] pmem_be_c;
    logic [ADDR_W-1:0] pmem_addr_c;
    logic [DATA_W-1:0] pmem_wdata_c;
    logic [DATA_W-1:0] i_rdata_c;
    logic              i_resp_c;
    logic [DATA_W-1:0] d_rdata_c;
    logic              d_resp_c;

    // Strobes follow the granted requester live so an abort drops them without a clock edge.
    always_comb begin
        pmem_read_c  = 1'b0;
        pmem_write_c = 1'b0;
        pmem_be_c    = {MASK_W{1'b1}};
        pmem_addr_c  = '0;
        pmem_wdata_c = '0;
        i_rdata_c    = '0;
        i_resp_c     = 1'b0;
        d_rdata_c    = '0;
        d_resp_c     = 1'b0;
        case (state_q)
            SERVE_I: begin
                pmem_read_c = bus.i_read;
                pmem_addr_c = bus.i_address;
                i_rdata_c   = bus.pmem_rdata;
                i_resp_c    = bus.pmem_resp;
            end
            SERVE_D: begin
                pmem_read_c  = bus.d_read & ~bus.d_write;
                pmem_write_c = bus.d_write;
                pmem_be_c    = bus.d_byte_enable;
                pmem_addr_c  = bus.d_address;
                pmem_wdata_c = bus.d_wdata;
                d_rdata_c    = bus.pmem_rdata;
                d_resp_c     = bus.pmem_resp;
            end
            default: ;
        endcase
    end

    assign bus.pmem_read        = pmem_read_c;
    assign bus.pmem_write       = pmem_write_c;
    assign bus.pmem_byte_enable = pmem_be_c;
    assign bus.pmem_address     = pmem_addr_c;
    assign bus.pmem_wdata       = pmem_wdata_c;
    assign bus.i_rdata          = i_rdata_c;
    assign bus.i_resp           = i_resp_c;
    assign bus.d_rdata          = d_rdata_c;
    assign bus.d_resp           = d_resp_c;

    d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(bus.d_read && bus.d_write));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: ROM-like memory model, per-side expectation queues, resp-driven monitor.
// Latency: n/a; backpressure: requesters hold strobes until resp, memory latency fixed or random 0..3.
module tb_mem_port_arbiter;
    logic clk;
    logic rst_n;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  be;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } txn_t;

    txn_t i_exp[$];
    txn_t d_exp[$];
    int   served[$];     // 0 = I, 1 = D, in completion order
    int   resp_cyc[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mem_lat = 0;     // negative: random 0..3
    logic mem_spurious = 1'b0;
    logic i_pend = 1'b0;
    logic d_pend = 1'b0;
    int   i_over_d = 0;  // I completions while D waits
    int   d_over_i = 0;  // D completions while I waits

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [15:0] rom(input logic [15:0] a);
        return a ^ 16'h1274;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Physical memory: answers after a latency counted from the first strobe cycle.
    initial begin
        int cnt;
        int cur;
        cnt = 0;
        cur = 0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.pmem_rdata = 16'($urandom);
            bus.pmem_resp  = 1'b0;
            if (!rst_n) cnt = 0;
            else if (mem_spurious) bus.pmem_resp = 1'b1;
            else if (bus.pmem_read || bus.pmem_write) begin
                if (cnt == 0) cur = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
                if (cnt >= cur) begin
                    bus.pmem_resp = 1'b1;
                    if (bus.pmem_read) bus.pmem_rdata = rom(bus.pmem_address);
                    cnt = 0;
                end else cnt++;
            end else cnt = 0;
        end
    end

    // Monitor: pops the expectation of whichever side gets a resp.
    initial begin
        txn_t e;
        logic prev_i, prev_d, have_last;
        int   last_cyc;
        prev_i = 0; prev_d = 0; have_last = 0; last_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_i = 0; prev_d = 0; have_last = 0;
            end else begin
                if (prev_i) chk("i_resp_one_cycle", bus.i_resp, 0);
                if (prev_d) chk("d_resp_one_cycle", bus.d_resp, 0);
                if (bus.i_resp || bus.d_resp) begin
                    chk("resp_exclusive", bus.i_resp & bus.d_resp, 0);
                    if (have_last) chk("idle_gap_min", (cyc - last_cyc) >= 2, 1);
                    have_last = 1;
                    last_cyc  = cyc;
                    resp_cyc.push_back(cyc);
                end
                if (bus.i_resp) begin
                    served.push_back(0);
                    chk("i_exp_present", i_exp.size() != 0, 1);
                    if (i_exp.size() != 0) begin
                        e = i_exp.pop_front();
                        chk("i_rdata", bus.i_rdata, e.rdata);
                        chk("i_pmem_addr", bus.pmem_address, e.addr);
                        chk("i_pmem_read", bus.pmem_read, 1);
                        chk("i_pmem_write", bus.pmem_write, 0);
                        chk("i_pmem_be", bus.pmem_byte_enable, 2'b11);
                        chk("d_rdata_ungranted", bus.d_rdata, 0);
                    end
                    if (d_pend) begin
                        i_over_d++;
                        chk("rr_bound_d_wait", i_over_d <= 1, 1);
                    end
                    d_over_i = 0;
                end
                if (bus.d_resp && !bus.i_resp) begin
                    served.push_back(1);
                    chk("d_exp_present", d_exp.size() != 0, 1);
                    if (d_exp.size() != 0) begin
                        e = d_exp.pop_front();
                        chk("d_pmem_write", bus.pmem_write, e.wr);
                        chk("d_pmem_read", bus.pmem_read, e.rd & ~e.wr);
                        chk("d_pmem_addr", bus.pmem_address, e.addr);
                        chk("d_pmem_be", bus.pmem_byte_enable, e.be);
                        chk("d_pmem_wdata", bus.pmem_wdata, e.wdata);
                        if (e.rd) chk("d_rdata", bus.d_rdata, e.rdata);
                        chk("i_rdata_ungranted", bus.i_rdata, 0);
                    end
                    if (i_pend) begin
                        d_over_i++;
                        chk("rr_bound_i_wait", d_over_i <= 1, 1);
                    end
                    i_over_d = 0;
                end
                prev_i = bus.i_resp;
                prev_d = bus.d_resp;
            end
        end
    end

    // Requester tasks are entered just after a rising edge.
    task automatic i_start(input logic [15:0] addr);
        txn_t t;
        t.rd = 1; t.wr = 0; t.be = 2'b11; t.addr = addr; t.wdata = '0; t.rdata = rom(addr);
        i_exp.push_back(t);
        i_pend = 1; i_over_d = 0;
        bus.i_read = 1; bus.i_address = addr;
    endtask

    task automatic i_finish();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.i_resp && n < 60);
        chk("i_resp_timeout", bus.i_resp, 1);
        if (!bus.i_resp && i_exp.size() != 0) i_exp.delete(i_exp.size() - 1);
        @(posedge clk); #1;
        bus.i_read = 0; i_pend = 0;
    endtask

    task automatic d_start(input logic rd, input logic wr, input logic [1:0] be,
                           input logic [15:0] addr, input logic [15:0] wdata);
        txn_t t;
        t.rd = rd; t.wr = wr; t.be = be; t.addr = addr; t.wdata = wdata; t.rdata = rom(addr);
        d_exp.push_back(t);
        d_pend = 1; d_over_i = 0;
        bus.d_read = rd; bus.d_write = wr; bus.d_byte_enable = be;
        bus.d_address = addr; bus.d_wdata = wdata;
    endtask

    task automatic d_finish();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.d_resp && n < 60);
        chk("d_resp_timeout", bus.d_resp, 1);
        if (!bus.d_resp && d_exp.size() != 0) d_exp.delete(d_exp.size() - 1);
        @(posedge clk); #1;
        bus.d_read = 0; bus.d_write = 0; d_pend = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic both_at_once(input logic [15:0] ia, input logic [15:0] da);
        served.delete();
        resp_cyc.delete();
        @(posedge clk); #1;
        fork
            begin i_start(ia); i_finish(); end
            begin d_start(1, 0, 2'b11, da, 16'h0); d_finish(); end
        join
    endtask

    initial begin
        rst_n = 0;
        bus.i_read = 0; bus.i_address = '0;
        bus.d_read = 0; bus.d_write = 0; bus.d_byte_enable = 2'b11;
        bus.d_address = '0; bus.d_wdata = '0;

        // Reset state
        @(negedge clk);
        chk("rst_pmem_read", bus.pmem_read, 0);
        chk("rst_pmem_write", bus.pmem_write, 0);
        chk("rst_pmem_be", bus.pmem_byte_enable, 2'b11);
        chk("rst_pmem_addr", bus.pmem_address, 0);
        chk("rst_pmem_wdata", bus.pmem_wdata, 0);
        chk("rst_resps", {bus.i_resp, bus.d_resp}, 0);
        chk("rst_rdata", {bus.i_rdata, bus.d_rdata}, 0);
        rst_n = 1;

        // Single instruction read, memory answers 3 cycles after the grant
        mem_lat = 3;
        @(posedge clk); #1;
        i_start(16'h0040);
        @(negedge clk);
        chk("t1_no_strobe_in_idle", bus.pmem_read, 0);
        @(negedge clk);
        chk("t1_strobe_next_cycle", bus.pmem_read, 1);
        chk("t1_addr", bus.pmem_address, 16'h0040);
        i_finish();
        @(negedge clk);
        chk("t1_idle_after", bus.pmem_read, 0);
        chk("t1_i_resp_low", bus.i_resp, 0);

        // Masked data write
        mem_lat = 1;
        @(posedge clk); #1;
        d_start(0, 1, 2'b10, 16'h0101, 16'hAB00);
        d_finish();

        // Simultaneous requests from reset, twice
        mem_lat = 0;
        pulse_reset();
        both_at_once(16'h0200, 16'h0300);
        chk("t3_count", served.size(), 2);
        chk("t3_first_is_i", served.size() > 0 ? served[0] : 9, 0);
        chk("t3_second_is_d", served.size() > 1 ? served[1] : 9, 1);
        chk("t3_resp_spacing", resp_cyc.size() > 1 ? resp_cyc[1] - resp_cyc[0] : 0, 2);
        both_at_once(16'h0210, 16'h0310);
        chk("t3b_first_is_i", served.size() > 0 ? served[0] : 9, 0);

        // Both held continuously, zero-wait memory
        served.delete();
        resp_cyc.delete();
        @(posedge clk); #1;
        fork
            begin
                for (int k = 0; k < 4; k++) begin i_start(16'h0400 + 16'(k)); i_finish(); end
            end
            begin
                for (int k = 0; k < 4; k++) begin d_start(1, 0, 2'b11, 16'h0480 + 16'(k), 16'h0); d_finish(); end
            end
        join
        chk("t4_count", served.size(), 8);
        for (int k = 1; k < served.size(); k++) begin
            chk("t4_alternate", served[k] != served[k-1], 1);
            chk("t4_two_cycles", resp_cyc[k] - resp_cyc[k-1], 2);
        end

        // Data read aborted after one cycle while an instruction read waits
        mem_lat = 10;
        @(posedge clk); #1;
        d_start(1, 0, 2'b11, 16'h0500, 16'h0);
        @(posedge clk); #1;
        i_start(16'h0600);
        @(negedge clk);
        chk("t5_d_strobe", bus.pmem_read, 1);
        chk("t5_d_addr", bus.pmem_address, 16'h0500);
        @(posedge clk); #1;
        bus.d_read = 0; d_pend = 0; mem_lat = 1;
        d_exp.delete(d_exp.size() - 1);
        #1;
        chk("t5_strobe_falls_now", bus.pmem_read, 0);
        @(negedge clk);
        chk("t5_no_d_resp", bus.d_resp, 0);
        @(negedge clk);
        chk("t5_idle_no_strobe", bus.pmem_read, 0);
        @(negedge clk);
        chk("t5_i_granted", bus.pmem_read, 1);
        chk("t5_i_addr", bus.pmem_address, 16'h0600);
        i_finish();

        // Memory resp while idle is ignored
        mem_spurious = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_resp_ignored", {bus.i_resp, bus.d_resp}, 0);
            chk("idle_rdata_zero", {bus.i_rdata, bus.d_rdata}, 0);
        end
        @(posedge clk); #1;
        mem_spurious = 0;

        // Asynchronous reset in the middle of a data write
        mem_lat = 10;
        @(posedge clk); #1;
        d_start(0, 1, 2'b01, 16'h0700, 16'h5555);
        @(negedge clk);
        @(negedge clk);
        chk("t6_write_on", bus.pmem_write, 1);
        #2;
        rst_n = 0;
        #1;
        chk("t6_write_off_async", bus.pmem_write, 0);
        chk("t6_addr_cleared", bus.pmem_address, 0);
        chk("t6_no_d_resp", bus.d_resp, 0);
        bus.d_write = 0; d_pend = 0;
        d_exp.delete(d_exp.size() - 1);
        @(negedge clk);
        rst_n = 1;
        mem_lat = 0;
        both_at_once(16'h0800, 16'h0900);
        chk("t6_first_is_i", served.size() > 0 ? served[0] : 9, 0);

        // Random traffic with random memory latency
        mem_lat = -1;
        @(posedge clk); #1;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    int g;
                    i_start(16'($urandom));
                    i_finish();
                    g = int'($urandom_range(0, 3));
                    if (g > 0) begin repeat (g) @(posedge clk); #1; end
                end
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    int g;
                    logic rd;
                    rd = 1'($urandom_range(0, 1));
                    d_start(rd, ~rd, 2'($urandom), 16'($urandom), 16'($urandom));
                    d_finish();
                    g = int'($urandom_range(0, 3));
                    if (g > 0) begin repeat (g) @(posedge clk); #1; end
                end
            end
        join
        repeat (3) @(negedge clk);
        chk("i_exp_drained", i_exp.size(), 0);
        chk("d_exp_drained", d_exp.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one physical memory port between two requesters: instruction side (i_*) and data side (d_*).
- Sits between the LC-3b control/datapath (or split I/D caches) and the single physical memory.
- Every port uses the codebase's level-held read/write + resp handshake.
- Round-robin arbitration, one transaction at a time, registered grant.

Parameters:
- ADDR_W, 16, address width (lc3b_word).
- DATA_W, 16, data width.
- MASK_W, 2, byte-enable width (lc3b_mem_wmask).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- i_read  in  1  instruction-side read request, held until i_resp.
- i_address  in  ADDR_W  instruction-side address.
- i_rdata  out  DATA_W  read data to instruction side.
- i_resp  out  1  one-cycle completion pulse to instruction side.
- d_read  in  1  data-side read request, held until d_resp.
- d_write  in  1  data-side write request, held until d_resp.
- d_byte_enable  in  MASK_W  data-side write mask.
- d_address  in  ADDR_W  data-side address.
- d_wdata  in  DATA_W  data-side write data.
- d_rdata  out  DATA_W  read data to data side.
- d_resp  out  1  one-cycle completion pulse to data side.
- pmem_read  out  1  physical read strobe.
- pmem_write  out  1  physical write strobe.
- pmem_byte_enable  out  MASK_W  physical byte mask.
- pmem_address  out  ADDR_W  physical address.
- pmem_wdata  out  DATA_W  physical write data.
- pmem_rdata  in  DATA_W  physical read data.
- pmem_resp  in  1  physical completion, one cycle per transaction.

Behaviour:
- States: IDLE, SERVE_I, SERVE_D. Register last_grant (0=I, 1=D).
- Reset (rst_n low, async): state=IDLE, last_grant=1 (I wins first tie). pmem_read=pmem_write=0, i_resp=d_resp=0. pmem_address, pmem_wdata, i_rdata, d_rdata=0. pmem_byte_enable=2'b11.
- i_req = i_read; d_req = d_read | d_write.
- IDLE, no requests: stay; all strobes 0.
- IDLE, only i_req: -> SERVE_I. Only d_req: -> SERVE_D.
- IDLE, both: grant the side not equal to last_grant.
- Entering a SERVE state sets last_grant to that side.
- No pmem strobe is driven in IDLE: request seen in cycle t, pmem strobe first asserted in cycle t+1.
- SERVE_I outputs:
  - pmem_read = i_read; pmem_write = 0; pmem_address = i_address; pmem_byte_enable = 2'b11.
  - i_rdata = pmem_rdata; i_resp = pmem_resp; d_resp = 0.
- SERVE_D outputs:
  - pmem_read = d_read & ~d_write; pmem_write = d_write.
  - pmem_address = d_address; pmem_wdata = d_wdata; pmem_byte_enable = d_byte_enable.
  - d_rdata = pmem_rdata; d_resp = pmem_resp; i_resp = 0.
- SERVE_x, pmem_resp=1: resp forwarded same cycle (combinational). -> IDLE next edge. Requester drops its strobe at that same edge (codebase handshake).
- Minimum 1 idle cycle between transactions, so a dropped request is never re-granted.
- SERVE_x, pmem_resp=0, request still held: stay; strobes and address forwarded live every cycle.
- Abort: the granted requester drops all strobes before pmem_resp -> IDLE next edge. No resp issued. pmem strobes fall in that same cycle.
- Read and write both asserted on the data side: protocol violation. Write wins, pmem_read=0. Simulation assertion fires.
- Non-granted requester: resp=0, rdata=0, request stays pending. Served at the next IDLE evaluation; round-robin bounds its wait to one transaction.
- pmem_resp while IDLE: ignored, no resp forwarded.
- rst_n asserted mid-transaction: immediate return to IDLE, all strobes 0, no resp; last_grant=1.
- Outputs i_resp and d_resp are never high in the same cycle.

Test Plan:
- Reset, then i_read=1, i_address=16'h0040. pmem_resp pulsed 3 cycles after the grant, pmem_rdata=16'h1234. -> pmem_read high from cycle t+1 with pmem_address=0040; i_resp=1 and i_rdata=1234 for exactly one cycle; state IDLE next.
- d_write=1, d_address=16'h0101, d_wdata=16'hAB00, d_byte_enable=2'b10. -> pmem_write=1, pmem_byte_enable=10, pmem_wdata=AB00; d_resp one pulse; i_resp stays 0.
- After reset, i_read and d_read rise in the same cycle. -> I served first, then 1 IDLE cycle, then D served. Repeat the simultaneous request -> I again, because last_grant alternates.
- Both requesters held continuously, zero-wait pmem_resp. -> grants alternate I,D,I,D; each transaction 2 cycles (serve + idle); no starvation.
- Granted d_read dropped after 1 cycle with no pmem_resp. -> pmem_read falls the same cycle, no d_resp, IDLE next cycle; a pending i_read is then granted.
- rst_n pulsed low asynchronously mid-SERVE_D. -> pmem_write=0 immediately without a clock edge; IDLE; a subsequent simultaneous request grants I first.
